// File: rtl/lsu_ctrl.sv
// Load/store unit: carries one data-memory access at a time over a req/gnt/rvalid port,
// steering store bytes onto their lanes and aligning/extending load data back to the core.
module lsu_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lsu_req_i,
  input  logic                      lsu_we_i,
  input  logic [1:0]                lsu_size_i,
  input  logic                      lsu_sign_ext_i,
  input  logic [MEM_ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]     lsu_wdata_i,
  output logic                      data_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] data_addr_o,
  output logic                      data_we_o,
  output logic [3:0]                data_be_o,
  output logic [DATA_WIDTH-1:0]     data_wdata_o,
  input  logic                      data_gnt_i,
  input  logic                      data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     data_rdata_i,
  output logic [DATA_WIDTH-1:0]     lsu_rdata_o,
  output logic                      valid_lsu_load_o,
  output logic                      valid_lsu_store_o,
  output logic                      misaligned_o,
  output logic                      lsu_busy_o
);

  localparam int NUM_LANES = DATA_WIDTH / 8;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID
  } state_t;

  state_t                    state_reg;
  logic                      we_reg;
  logic [1:0]                size_reg;
  logic                      sext_reg;
  logic [1:0]                off_reg;
  logic                      req_reg;
  logic [MEM_ADDR_WIDTH-1:0] addr_reg;
  logic [3:0]                be_reg;
  logic [DATA_WIDTH-1:0]     wdata_reg;
  logic [DATA_WIDTH-1:0]     rdata_reg;
  logic                      load_pulse_reg;
  logic                      store_pulse_reg;
  logic                      mis_pulse_reg;

  logic                      misaligned_next;
  logic [3:0]                be_next;
  logic [DATA_WIDTH-1:0]     wdata_next;
  logic [DATA_WIDTH-1:0]     rdata_shifted;
  logic [DATA_WIDTH-1:0]     rdata_next;

  always_comb begin
    misaligned_next = 1'b0;
    case (lsu_size_i)
      SIZE_BYTE: misaligned_next = 1'b0;
      SIZE_HALF: misaligned_next = lsu_addr_i[0];
      SIZE_WORD: misaligned_next = |lsu_addr_i[1:0];
      default:   misaligned_next = 1'b1;
    endcase
  end

  always_comb begin
    be_next = 4'b1111;
    case (lsu_size_i)
      SIZE_BYTE: be_next = 4'b0001 << lsu_addr_i[1:0];
      SIZE_HALF: be_next = 4'b0011 << lsu_addr_i[1:0];
      default:   be_next = 4'b1111;
    endcase
  end

  // Replicate the store operand across lanes so the memory only needs the byte enables.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign wdata_next[gi*8 +: 8] =
        (lsu_size_i == SIZE_BYTE) ? lsu_wdata_i[7:0] :
        (lsu_size_i == SIZE_HALF) ? lsu_wdata_i[(gi%2)*8 +: 8] :
                                    lsu_wdata_i[gi*8 +: 8];
    end
  endgenerate

  assign rdata_shifted = data_rdata_i >> {off_reg, 3'b000};

  always_comb begin
    rdata_next = rdata_shifted;
    case (size_reg)
      SIZE_BYTE: rdata_next = {{(DATA_WIDTH-8){sext_reg & rdata_shifted[7]}}, rdata_shifted[7:0]};
      SIZE_HALF: rdata_next = {{(DATA_WIDTH-16){sext_reg & rdata_shifted[15]}}, rdata_shifted[15:0]};
      default:   rdata_next = rdata_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      we_reg          <= 1'b0;
      size_reg        <= SIZE_BYTE;
      sext_reg        <= 1'b0;
      off_reg         <= 2'b00;
      req_reg         <= 1'b0;
      addr_reg        <= '0;
      be_reg          <= 4'b0000;
      wdata_reg       <= '0;
      rdata_reg       <= '0;
      load_pulse_reg  <= 1'b0;
      store_pulse_reg <= 1'b0;
      mis_pulse_reg   <= 1'b0;
    end else begin
      load_pulse_reg  <= 1'b0;
      store_pulse_reg <= 1'b0;
      mis_pulse_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (lsu_req_i) begin
            if (misaligned_next) begin
              mis_pulse_reg <= 1'b1;
            end else begin
              we_reg    <= lsu_we_i;
              size_reg  <= lsu_size_i;
              sext_reg  <= lsu_sign_ext_i;
              off_reg   <= lsu_addr_i[1:0];
              addr_reg  <= {lsu_addr_i[MEM_ADDR_WIDTH-1:2], 2'b00};
              be_reg    <= be_next;
              wdata_reg <= wdata_next;
              req_reg   <= 1'b1;
              state_reg <= WAIT_GNT;
            end
          end
        end
        WAIT_GNT: begin
          if (data_gnt_i) begin
            req_reg   <= 1'b0;
            state_reg <= WAIT_RVALID;
          end
        end
        WAIT_RVALID: begin
          if (data_rvalid_i) begin
            state_reg <= IDLE;
            if (we_reg) begin
              store_pulse_reg <= 1'b1;
            end else begin
              rdata_reg      <= rdata_next;
              load_pulse_reg <= 1'b1;
            end
          end
        end
        default: begin
          req_reg   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign data_req_o        = req_reg;
  assign data_addr_o       = addr_reg;
  assign data_we_o         = we_reg;
  assign data_be_o         = be_reg;
  assign data_wdata_o      = wdata_reg;
  assign lsu_rdata_o       = rdata_reg;
  assign valid_lsu_load_o  = load_pulse_reg;
  assign valid_lsu_store_o = store_pulse_reg;
  assign misaligned_o      = mis_pulse_reg;
  assign lsu_busy_o        = (state_reg != IDLE);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed test-plan accesses with literal expectations, then random
// requests and memory timing checked every cycle against a transaction-level model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [1:0]  lsu_size_i;
  logic        lsu_sign_ext_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        data_req_o;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic [31:0] lsu_rdata_o;
  logic        valid_lsu_load_o;
  logic        valid_lsu_store_o;
  logic        misaligned_o;
  logic        lsu_busy_o;

  int vectors     = 0;
  int miscompares = 0;

  lsu_ctrl #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .lsu_rdata_o(lsu_rdata_o),
    .valid_lsu_load_o(valid_lsu_load_o), .valid_lsu_store_o(valid_lsu_store_o),
    .misaligned_o(misaligned_o), .lsu_busy_o(lsu_busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic logic m_misaligned(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    int off;
    off = int'(addr % 4);
    case (size)
      2'd0:    return 4'(1 << off);
      2'd1:    return 4'(3 << off);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'd0:    return (wdata & 32'hFF) * 32'h01010101;
      2'd1:    return (wdata & 32'hFFFF) * 32'h00010001;
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic sext,
                                         input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] v;
    sh = rdata >> (8 * (addr % 4));
    v  = sh;
    if (size == 2'd0) begin
      v = sh & 32'hFF;
      if (sext && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = sh & 32'hFFFF;
      if (sext && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  logic        model_live = 1'b0;
  logic        m_out = 1'b0, m_gr = 1'b0, m_we = 1'b0, m_sext = 1'b0;
  logic [1:0]  m_size = 2'd0;
  logic [31:0] m_addr = '0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rdata = '0;
  logic [3:0]  exp_be = '0;
  logic        exp_we = 1'b0, exp_load = 1'b0, exp_store = 1'b0, exp_mis = 1'b0;

  task automatic model_step();
    exp_load  = 1'b0;
    exp_store = 1'b0;
    exp_mis   = 1'b0;
    if (rst) begin
      m_out = 1'b0; m_gr = 1'b0;
      exp_addr = '0; exp_be = '0; exp_we = 1'b0; exp_wdata = '0; exp_rdata = '0;
      model_live = 1'b1;
      return;
    end
    if (!model_live) return;
    if (!m_out) begin
      if (lsu_req_i) begin
        if (m_misaligned(lsu_size_i, lsu_addr_i)) begin
          exp_mis = 1'b1;
          $display("txn misaligned size=%0d addr=%h", lsu_size_i, lsu_addr_i);
        end else begin
          m_out = 1'b1; m_gr = 1'b0;
          m_we = lsu_we_i; m_size = lsu_size_i; m_sext = lsu_sign_ext_i; m_addr = lsu_addr_i;
          exp_addr  = lsu_addr_i & ~32'h3;
          exp_be    = m_be(lsu_size_i, lsu_addr_i);
          exp_we    = lsu_we_i;
          exp_wdata = m_wdata(lsu_size_i, lsu_wdata_i);
        end
      end
    end else if (!m_gr) begin
      m_gr = data_gnt_i;
    end else if (data_rvalid_i) begin
      m_out = 1'b0;
      if (m_we) begin
        exp_store = 1'b1;
        $display("txn store size=%0d addr=%h be=%b wdata=%h", m_size, m_addr, exp_be, exp_wdata);
      end else begin
        exp_load  = 1'b1;
        exp_rdata = m_load(m_size, m_sext, m_addr, data_rdata_i);
        $display("txn load  size=%0d sext=%0d addr=%h rdata=%h", m_size, m_sext, m_addr, exp_rdata);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Single compare process: every output, every cycle, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        chk("req",    32'(data_req_o),        32'(m_out && !m_gr));
        chk("busy",   32'(lsu_busy_o),        32'(m_out));
        chk("addr",   data_addr_o,            exp_addr);
        chk("be",     32'(data_be_o),         32'(exp_be));
        chk("we",     32'(data_we_o),         32'(exp_we));
        chk("wdata",  data_wdata_o,           exp_wdata);
        chk("rdata",  lsu_rdata_o,            exp_rdata);
        chk("vload",  32'(valid_lsu_load_o),  32'(exp_load));
        chk("vstore", 32'(valid_lsu_store_o), 32'(exp_store));
        chk("mis",    32'(misaligned_o),      32'(exp_mis));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic access(input string tag, input logic we, input logic [1:0] size, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        input int gnt_dly, input logic [31:0] x_addr, input logic [3:0] x_be,
                        input logic [31:0] x_wdata, input logic [31:0] x_rdata);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_sign_ext_i = sext;
    lsu_addr_i = addr; lsu_wdata_i = wdata;
    cyc();
    lsu_req_i = 1'b0;
    for (int i = 0; i <= gnt_dly; i++) begin
      chk({tag, "_req"},  32'(data_req_o), 32'd1);
      chk({tag, "_addr"}, data_addr_o, x_addr);
      chk({tag, "_be"},   32'(data_be_o), 32'(x_be));
      chk({tag, "_we"},   32'(data_we_o), 32'(we));
      if (we) chk({tag, "_wdata"}, data_wdata_o, x_wdata);
      data_gnt_i = (i == gnt_dly);
      cyc();
    end
    data_gnt_i = 1'b0;
    chk({tag, "_req_drop"}, 32'(data_req_o), 32'd0);
    chk({tag, "_busy"},     32'(lsu_busy_o), 32'd1);
    data_rvalid_i = 1'b1; data_rdata_i = rdata;
    cyc();
    data_rvalid_i = 1'b0;
    if (we) begin
      chk({tag, "_vstore"}, 32'(valid_lsu_store_o), 32'd1);
    end else begin
      chk({tag, "_vload"}, 32'(valid_lsu_load_o), 32'd1);
      chk({tag, "_rdata"}, lsu_rdata_o, x_rdata);
    end
    chk({tag, "_idle"}, 32'(lsu_busy_o), 32'd0);
    cyc();
    chk({tag, "_pulse_end"}, 32'(valid_lsu_load_o | valid_lsu_store_o), 32'd0);
  endtask

  logic pend = 1'b0, req_seen = 1'b0;
  int   dly = 0;

  // Memory responder: random grant delay, random response delay, occasional stray rvalid.
  task automatic mem_step();
    if (req_seen && data_gnt_i) begin
      pend = 1'b1;
      dly  = $urandom_range(0, 3);
    end else if (pend && data_rvalid_i) begin
      pend = 1'b0;
    end
    req_seen   = data_req_o;
    data_gnt_i = data_req_o ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
    if (pend && dly == 0) begin
      data_rvalid_i = 1'b1;
    end else begin
      if (pend) dly--;
      data_rvalid_i = !pend && ($urandom_range(0, 9) == 0);
    end
    data_rdata_i = $urandom();
  endtask

  initial begin
    int r;
    rst = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'd0; lsu_sign_ext_i = 1'b0;
    lsu_addr_i = '0; lsu_wdata_i = '0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
    repeat (3) cyc();
    chk("rst_req",   32'(data_req_o), 32'd0);
    chk("rst_busy",  32'(lsu_busy_o), 32'd0);
    chk("rst_addr",  data_addr_o,     32'd0);
    chk("rst_be",    32'(data_be_o),  32'd0);
    chk("rst_wdata", data_wdata_o,    32'd0);
    chk("rst_rdata", lsu_rdata_o,     32'd0);
    chk("rst_pulse", 32'(valid_lsu_load_o | valid_lsu_store_o | misaligned_o), 32'd0);
    rst = 1'b0;
    cyc();

    access("ldw",   1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 32'h100, 4'hF, 32'h0,        32'hDEADBEEF);
    access("ldb_s", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0,        32'h80FF0000, 0, 32'h100, 4'h8, 32'h0,        32'hFFFFFF80);
    access("ldb_u", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        32'h80FF0000, 1, 32'h100, 4'h8, 32'h0,        32'h00000080);
    access("sth",   1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'h0,        3, 32'h200, 4'hC, 32'hABCDABCD, 32'h0);
    access("ldh_s", 1'b0, 2'b01, 1'b1, 32'h006, 32'h0,        32'h9234_0000, 2, 32'h004, 4'hC, 32'h0,        32'hFFFF9234);

    // Misaligned word load: rejected with a pulse, no memory activity.
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b10; lsu_addr_i = 32'h101;
    cyc();
    lsu_req_i = 1'b0;
    chk("mis_pulse", 32'(misaligned_o), 32'd1);
    chk("mis_req",   32'(data_req_o),   32'd0);
    chk("mis_busy",  32'(lsu_busy_o),   32'd0);
    cyc();
    chk("mis_pulse_end", 32'(misaligned_o), 32'd0);
    chk("mis_req2",      32'(data_req_o),   32'd0);

    // Reset while waiting for rvalid; the late response must be ignored.
    lsu_req_i = 1'b1; lsu_size_i = 2'b10; lsu_addr_i = 32'h300;
    cyc();
    lsu_req_i = 1'b0; data_gnt_i = 1'b1;
    cyc();
    data_gnt_i = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rstmid_req",   32'(data_req_o), 32'd0);
    chk("rstmid_busy",  32'(lsu_busy_o), 32'd0);
    chk("rstmid_addr",  data_addr_o,     32'd0);
    chk("rstmid_rdata", lsu_rdata_o,     32'd0);
    data_rvalid_i = 1'b1; data_rdata_i = 32'h5555AAAA;
    cyc();
    data_rvalid_i = 1'b0;
    chk("rstmid_vload", 32'(valid_lsu_load_o), 32'd0);
    chk("rstmid_rdata2", lsu_rdata_o, 32'd0);
    cyc();

    // Back-to-back: second request held while busy, accepted in the pulse cycle.
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b10; lsu_addr_i = 32'h400;
    cyc();
    lsu_we_i = 1'b1; lsu_addr_i = 32'h500; lsu_wdata_i = 32'hCAFEF00D;
    chk("b2b_addr1", data_addr_o, 32'h400);
    data_gnt_i = 1'b1;
    cyc();
    data_gnt_i = 1'b0;
    chk("b2b_addr_hold", data_addr_o, 32'h400);
    data_rvalid_i = 1'b1; data_rdata_i = 32'h12345678;
    cyc();
    data_rvalid_i = 1'b0;
    chk("b2b_vload", 32'(valid_lsu_load_o), 32'd1);
    chk("b2b_rdata", lsu_rdata_o, 32'h12345678);
    chk("b2b_addr_pulse", data_addr_o, 32'h400);
    cyc();
    lsu_req_i = 1'b0;
    chk("b2b_req2",   32'(data_req_o), 32'd1);
    chk("b2b_addr2",  data_addr_o, 32'h500);
    chk("b2b_we2",    32'(data_we_o), 32'd1);
    chk("b2b_wdata2", data_wdata_o, 32'hCAFEF00D);
    data_gnt_i = 1'b1;
    cyc();
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
    cyc();
    data_rvalid_i = 1'b0;
    chk("b2b_vstore", 32'(valid_lsu_store_o), 32'd1);
    cyc();

    // Random phase.
    for (int c = 0; c < 3000; c++) begin
      mem_step();
      rst = ($urandom_range(0, 299) == 0);
      if (!lsu_busy_o || $urandom_range(0, 3) == 0) begin
        lsu_req_i = ($urandom_range(0, 9) < 6);
        lsu_we_i  = $urandom_range(0, 1);
        r = $urandom_range(0, 9);
        lsu_size_i     = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        lsu_sign_ext_i = $urandom_range(0, 1);
        lsu_addr_i     = $urandom();
        lsu_wdata_i    = $urandom();
      end
      cyc();
    end

    // Drain the outstanding access with a bounded wait.
    rst = 1'b0; lsu_req_i = 1'b0;
    for (int c = 0; c < 40 && lsu_busy_o; c++) begin
      mem_step();
      cyc();
    end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    chk("drain_idle", 32'(lsu_busy_o), 32'd0);
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
